// File: rtl/axi4_lite_timer_slave_pkg.sv
// Shared constants and FSM state types for the AXI4-Lite timer register slave.
// Register offsets are word indices taken from addr[3:2].
package axi4_lite_timer_pkg;

  localparam logic [1:0] REG_LOAD   = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_COUNT  = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_STOP_BIT  = 1;
  localparam int STATUS_EXP_BIT = 0;

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} wr_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rd_state_t;

  function automatic logic [1:0] resp_of(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi4_lite_timer_slave_if.sv
// AXI4-Lite bus bundle between the interconnect (master) and the timer slave.
// Every channel transfers on a rising edge where valid and ready are both 1; valid never waits on ready and holds its payload until then.
interface axi4_lite_timer_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi4_lite_timer_slave_regbank.sv
// Timer register storage: byte-strobed LOAD, CTRL start/stop pulses, running bit,
// sticky expiry flag with write-one-to-clear, and the combinational read mux.
module axi4_lite_timer_regbank
  import axi4_lite_timer_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 32,
  parameter logic [31:0] LOAD_RST = 32'h0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_wr_en,
  input  logic [ADDR_W-1:0]   i_wr_addr,
  input  logic [DATA_W-1:0]   i_wr_data,
  input  logic [DATA_W/8-1:0] i_wr_strb,
  output logic                o_wr_err,
  input  logic [ADDR_W-1:0]   i_rd_addr,
  output logic [DATA_W-1:0]   o_rd_data,
  output logic                o_rd_err,
  input  logic                i_expired,
  input  logic [DATA_W-1:0]   i_count_value,
  output logic [DATA_W-1:0]   o_load_value,
  output logic                o_start,
  output logic                o_stop
);

  logic [DATA_W-1:0] r_load;
  logic              r_start;
  logic              r_stop;
  logic              r_running;
  logic              r_exp_flag;

  logic [1:0] w_wr_idx;
  logic [1:0] w_rd_idx;
  logic       w_wr_ok;
  logic       w_ctrl_wr;
  logic       w_start_req;
  logic       w_stop_req;
  logic       w_clr_req;
  logic       w_load_wr;
  logic       w_unused_addr_bits;

  assign w_wr_idx  = i_wr_addr[3:2];
  assign w_rd_idx  = i_rd_addr[3:2];
  assign o_wr_err  = (|i_wr_addr[ADDR_W-1:4]) || (w_wr_idx == REG_COUNT);
  assign o_rd_err  = |i_rd_addr[ADDR_W-1:4];
  assign w_wr_ok   = i_wr_en && !o_wr_err;
  assign w_load_wr = w_wr_ok && (w_wr_idx == REG_LOAD);
  assign w_ctrl_wr = w_wr_ok && (w_wr_idx == REG_CTRL) && i_wr_strb[0];
  // Stop dominates when both command bits are set.
  assign w_stop_req  = w_ctrl_wr && i_wr_data[CTRL_STOP_BIT];
  assign w_start_req = w_ctrl_wr && i_wr_data[CTRL_START_BIT] && !i_wr_data[CTRL_STOP_BIT];
  assign w_clr_req   = w_wr_ok && (w_wr_idx == REG_STATUS) && i_wr_strb[0]
                       && i_wr_data[STATUS_EXP_BIT];
  assign w_unused_addr_bits = ^{i_wr_addr[1:0], i_rd_addr[1:0]};

  assign o_load_value = r_load;
  assign o_start      = r_start;
  assign o_stop       = r_stop;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_load     <= LOAD_RST;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
      r_running  <= 1'b0;
      r_exp_flag <= 1'b0;
    end else begin
      r_start <= w_start_req;
      r_stop  <= w_stop_req;
      if (w_stop_req || i_expired) r_running <= 1'b0;
      else if (w_start_req)        r_running <= 1'b1;
      // A live expiry beats a same-cycle clear so no event is lost.
      if (i_expired)      r_exp_flag <= 1'b1;
      else if (w_clr_req) r_exp_flag <= 1'b0;
      if (w_load_wr) begin
        for (int i = 0; i < DATA_W/8; i++) begin
          if (i_wr_strb[i]) r_load[8*i +: 8] <= i_wr_data[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    o_rd_data = '0;
    if (!o_rd_err) begin
      case (w_rd_idx)
        REG_LOAD:   o_rd_data = r_load;
        REG_CTRL:   o_rd_data = {{(DATA_W-1){1'b0}}, r_running};
        REG_STATUS: o_rd_data = {{(DATA_W-1){1'b0}}, r_exp_flag};
        default:    o_rd_data = i_count_value;
      endcase
    end
  end

endmodule

// File: rtl/axi4_lite_timer_slave.sv
// AXI4-Lite slave front end for the hardware timer: independent write and read
// channel FSMs around the axi4_lite_timer_regbank register block.
module axi4_lite_timer_slave
  import axi4_lite_timer_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 32,
  parameter logic [31:0] LOAD_RST = 32'h0
) (
  input  logic                    clk,
  input  logic                    reset,
  axi4_lite_timer_slave_if.slave  s_axi,
  output logic [DATA_W-1:0]       o_load_value,
  output logic                    o_start,
  output logic                    o_stop,
  input  logic                    i_expired,
  input  logic [DATA_W-1:0]       i_count_value,
  output wr_state_t               o_wr_state,
  output rd_state_t               o_rd_state
);

  wr_state_t r_wstate, w_wstate_nxt;
  rd_state_t r_rstate, w_rstate_nxt;

  logic                r_aw_got;
  logic                r_w_got;
  logic [ADDR_W-1:0]   r_awaddr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wstrb;
  logic [1:0]          r_bresp;
  logic [DATA_W-1:0]   r_rdata;
  logic [1:0]          r_rresp;

  logic                w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic [ADDR_W-1:0]   w_wr_addr;
  logic [DATA_W-1:0]   w_wr_data;
  logic [DATA_W/8-1:0] w_wr_strb;
  logic                w_wr_err, w_rd_err;
  logic [DATA_W-1:0]   w_rd_data;

  assign s_axi.awready = (r_wstate == W_IDLE) && !r_aw_got;
  assign s_axi.wready  = (r_wstate == W_IDLE) && !r_w_got;
  assign s_axi.bvalid  = (r_wstate == W_RESP);
  assign s_axi.bresp   = r_bresp;
  assign s_axi.arready = (r_rstate == R_IDLE);
  assign s_axi.rvalid  = (r_rstate == R_DATA);
  assign s_axi.rdata   = r_rdata;
  assign s_axi.rresp   = r_rresp;
  assign o_wr_state    = r_wstate;
  assign o_rd_state    = r_rstate;

  assign w_aw_hs = s_axi.awvalid && s_axi.awready;
  assign w_w_hs  = s_axi.wvalid && s_axi.wready;
  assign w_ar_hs = s_axi.arvalid && s_axi.arready;
  // Commit in the cycle the second half arrives, using live bus values for whichever half is arriving now.
  assign w_commit  = (r_wstate == W_IDLE) && (r_aw_got || w_aw_hs) && (r_w_got || w_w_hs);
  assign w_wr_addr = r_aw_got ? r_awaddr : s_axi.awaddr;
  assign w_wr_data = r_w_got ? r_wdata : s_axi.wdata;
  assign w_wr_strb = r_w_got ? r_wstrb : s_axi.wstrb;

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_commit) w_wstate_nxt = W_RESP;
      W_RESP:  if (s_axi.bready) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
      R_DATA:  if (s_axi.rready) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
    end else begin
      r_wstate <= w_wstate_nxt;
      r_rstate <= w_rstate_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_aw_got <= 1'b0;
      r_w_got  <= 1'b0;
      r_awaddr <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_bresp  <= RESP_OKAY;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else begin
      if (w_commit) begin
        r_aw_got <= 1'b0;
        r_w_got  <= 1'b0;
        r_bresp  <= resp_of(w_wr_err);
      end else begin
        if (w_aw_hs) begin
          r_aw_got <= 1'b1;
          r_awaddr <= s_axi.awaddr;
        end
        if (w_w_hs) begin
          r_w_got <= 1'b1;
          r_wdata <= s_axi.wdata;
          r_wstrb <= s_axi.wstrb;
        end
      end
      if (w_ar_hs) begin
        r_rdata <= w_rd_data;
        r_rresp <= resp_of(w_rd_err);
      end
    end
  end

  axi4_lite_timer_regbank #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .LOAD_RST (LOAD_RST)
  ) u_regbank (
    .clk           (clk),
    .reset         (reset),
    .i_wr_en       (w_commit),
    .i_wr_addr     (w_wr_addr),
    .i_wr_data     (w_wr_data),
    .i_wr_strb     (w_wr_strb),
    .o_wr_err      (w_wr_err),
    .i_rd_addr     (s_axi.araddr),
    .o_rd_data     (w_rd_data),
    .o_rd_err      (w_rd_err),
    .i_expired     (i_expired),
    .i_count_value (i_count_value),
    .o_load_value  (o_load_value),
    .o_start       (o_start),
    .o_stop        (o_stop)
  );

endmodule

// File: tb/tb_axi4_lite_timer_slave.sv
// Bench for axi4_lite_timer_slave: directed register scenarios plus random traffic,
// checked by B/R monitors against an abstract register model.
module tb_axi4_lite_timer_slave;
  import axi4_lite_timer_pkg::*;

  localparam int          ADDR_W   = 32;
  localparam int          DATA_W   = 32;
  localparam logic [31:0] LOAD_RST = 32'h0;

  // ---------------- clock / reset / DUT ----------------
  logic        clk;
  logic        reset;
  logic [31:0] load_value;
  logic        start;
  logic        stop;
  logic        expired;
  logic [31:0] count_value;
  wr_state_t   wr_state;
  rd_state_t   rd_state;

  axi4_lite_timer_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  axi4_lite_timer_slave #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .LOAD_RST (LOAD_RST)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .s_axi         (bus),
    .o_load_value  (load_value),
    .o_start       (start),
    .o_stop        (stop),
    .i_expired     (expired),
    .i_count_value (count_value),
    .o_wr_state    (wr_state),
    .o_rd_state    (rd_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [1:0]  exp_b_q[$];
  logic [33:0] exp_r_q[$];
  bit b_hold = 1'b0;
  bit r_hold = 1'b0;
  int n_starts = 0;
  int n_stops  = 0;

  // reference model: plain register values and event counts
  logic [31:0] m_load;
  bit          m_running;
  bit          m_exp;
  int          m_starts = 0;
  int          m_stops  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: expected event did not occur at %0t", name, $time);
  endtask

  function automatic void model_reset();
    m_load    = LOAD_RST;
    m_running = 1'b0;
    m_exp     = 1'b0;
  endfunction

  function automatic void model_write(input logic [31:0] addr, input logic [31:0] data,
                                      input logic [3:0] strb, input bit exp_now);
    logic [1:0] idx;
    idx = addr[3:2];
    if (addr[31:4] != 28'h0 || idx == REG_COUNT) begin
      exp_b_q.push_back(RESP_SLVERR);
    end else begin
      exp_b_q.push_back(RESP_OKAY);
      if (idx == REG_LOAD) begin
        for (int i = 0; i < 4; i++)
          if (strb[i]) m_load[8*i +: 8] = data[8*i +: 8];
      end else if (idx == REG_CTRL && strb[0]) begin
        if (data[1]) begin
          m_stops++;
          m_running = 1'b0;
        end else if (data[0]) begin
          m_starts++;
          m_running = 1'b1;
        end
      end else if (idx == REG_STATUS && strb[0] && data[0]) begin
        m_exp = 1'b0;
      end
    end
    if (exp_now) begin
      m_exp     = 1'b1;
      m_running = 1'b0;
    end
  endfunction

  function automatic logic [33:0] model_read(input logic [31:0] addr);
    logic [33:0] r;
    if (addr[31:4] != 28'h0) r = {RESP_SLVERR, 32'h0};
    else begin
      case (addr[3:2])
        REG_LOAD:   r = {RESP_OKAY, m_load};
        REG_CTRL:   r = {RESP_OKAY, 31'h0, m_running};
        REG_STATUS: r = {RESP_OKAY, 31'h0, m_exp};
        default:    r = {RESP_OKAY, count_value};
      endcase
    end
    return r;
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (start) n_starts++;
    if (stop)  n_stops++;
  end

  logic [1:0]  mon_b;
  logic [33:0] mon_r;
  always @(negedge clk) begin
    if (bus.bvalid && !b_hold && $urandom_range(0, 3) != 0) begin
      bus.bready = 1'b1;
      if (exp_b_q.size() == 0) fail_now("b_unexpected");
      else begin
        mon_b = exp_b_q.pop_front();
        check("bresp", 32'(bus.bresp), 32'(mon_b));
      end
    end else begin
      bus.bready = 1'b0;
    end
    if (bus.rvalid && !r_hold && $urandom_range(0, 3) != 0) begin
      bus.rready = 1'b1;
      if (exp_r_q.size() == 0) fail_now("r_unexpected");
      else begin
        mon_r = exp_r_q.pop_front();
        check("rresp", 32'(bus.rresp), 32'(mon_r[33:32]));
        check("rdata", bus.rdata, mon_r[31:0]);
      end
    end else begin
      bus.rready = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_b();
    int g;
    g = 0;
    while (exp_b_q.size() != 0 && g < 60) begin
      @(negedge clk);
      g++;
    end
    if (exp_b_q.size() != 0) begin
      fail_now("b_timeout");
      exp_b_q.delete();
    end
    @(negedge clk);
    check("load_value", load_value, m_load);
    check("start_pulses", 32'(n_starts), 32'(m_starts));
    check("stop_pulses", 32'(n_stops), 32'(m_stops));
  endtask

  task automatic wait_r();
    int g;
    g = 0;
    while (exp_r_q.size() != 0 && g < 60) begin
      @(negedge clk);
      g++;
    end
    if (exp_r_q.size() != 0) begin
      fail_now("r_timeout");
      exp_r_q.delete();
    end
  endtask

  // mode 0: AW then W, 1: W then AW, 2: same cycle; exp_now raises expired in the commit cycle (mode 2)
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int mode, input bit exp_now, input bit wait_resp);
    bit aw_done, w_done, hs_aw, hs_w;
    int guard;
    @(negedge clk);
    model_write(addr, data, strb, exp_now);
    bus.awaddr = addr;
    bus.wdata  = data;
    bus.wstrb  = strb;
    aw_done = 1'b0;
    w_done  = 1'b0;
    guard   = 0;
    if (exp_now) expired = 1'b1;
    while (!(aw_done && w_done) && guard < 30) begin
      bus.awvalid = !aw_done && (mode != 1 || w_done);
      bus.wvalid  = !w_done && (mode != 0 || aw_done);
      hs_aw = bus.awvalid && bus.awready;
      hs_w  = bus.wvalid && bus.wready;
      @(negedge clk);
      expired = 1'b0;
      if (hs_aw) begin
        aw_done = 1'b1;
        check("awready_after_aw", 32'(bus.awready), 32'h0);
      end
      if (hs_w) begin
        w_done = 1'b1;
        check("wready_after_w", 32'(bus.wready), 32'h0);
      end
      guard++;
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    if (!(aw_done && w_done)) fail_now("write_handshake_timeout");
    else check("bvalid_latency", 32'(bus.bvalid), 32'h1);
    if (wait_resp) wait_b();
  endtask

  task automatic axi_read(input logic [31:0] addr, input bit wait_resp);
    bit done, hs;
    int guard;
    @(negedge clk);
    count_value = $urandom;
    exp_r_q.push_back(model_read(addr));
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    done  = 1'b0;
    guard = 0;
    while (!done && guard < 30) begin
      hs = bus.arready;
      @(negedge clk);
      if (hs) done = 1'b1;
      guard++;
    end
    bus.arvalid = 1'b0;
    if (!done) fail_now("read_handshake_timeout");
    else begin
      check("arready_after_ar", 32'(bus.arready), 32'h0);
      check("rvalid_latency", 32'(bus.rvalid), 32'h1);
    end
    if (wait_resp) wait_r();
  endtask

  task automatic pulse_expired();
    @(negedge clk);
    expired = 1'b1;
    @(negedge clk);
    expired   = 1'b0;
    m_exp     = 1'b1;
    m_running = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_awready"}, 32'(bus.awready), 32'h1);
    check({tag, "_wready"},  32'(bus.wready),  32'h1);
    check({tag, "_arready"}, 32'(bus.arready), 32'h1);
    check({tag, "_bvalid"},  32'(bus.bvalid),  32'h0);
    check({tag, "_rvalid"},  32'(bus.rvalid),  32'h0);
    check({tag, "_bresp"},   32'(bus.bresp),   32'h0);
    check({tag, "_rresp"},   32'(bus.rresp),   32'h0);
    check({tag, "_rdata"},   bus.rdata,        32'h0);
    check({tag, "_load"},    load_value,       LOAD_RST);
    check({tag, "_start"},   32'(start),       32'h0);
    check({tag, "_stop"},    32'(stop),        32'h0);
    check({tag, "_wstate"},  32'(wr_state),    32'(W_IDLE));
    check({tag, "_rstate"},  32'(rd_state),    32'(R_IDLE));
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] a;
    case ($urandom_range(0, 7))
      0: a = 32'h0000_0000;
      1: a = 32'h0000_0004;
      2: a = 32'h0000_0008;
      3: a = 32'h0000_000C;
      4: a = 32'h0000_0010;
      5: a = 32'h0000_0040;
      6: a = 32'h8000_0004;
      default: a = 32'h0000_0000;
    endcase
    return a | 32'($urandom_range(0, 3));
  endfunction

  // ---------------- main stimulus ----------------
  initial begin
    int op;
    logic [31:0] ra;
    logic [31:0] rd;
    reset       = 1'b1;
    expired     = 1'b0;
    count_value = 32'h0;
    bus.awaddr  = '0;
    bus.awvalid = 1'b0;
    bus.wdata   = '0;
    bus.wstrb   = '0;
    bus.wvalid  = 1'b0;
    bus.araddr  = '0;
    bus.arvalid = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;

    // LOAD write, AW ahead of W
    axi_write(32'h0, 32'h5, 4'hF, 0, 1'b0, 1'b1);
    axi_read(32'h0, 1'b1);
    // CTRL start, AW/W together
    axi_write(32'h4, 32'h1, 4'hF, 2, 1'b0, 1'b1);
    axi_read(32'h4, 1'b1);
    // CTRL start+stop: stop only
    axi_write(32'h4, 32'h3, 4'hF, 1, 1'b0, 1'b1);
    axi_read(32'h4, 1'b1);
    // CTRL without lane 0 strobe: no action
    axi_write(32'h4, 32'h1, 4'b1110, 2, 1'b0, 1'b1);
    axi_read(32'h4, 1'b1);
    // expiry flag set, cleared, and clear losing to a live expiry
    pulse_expired();
    axi_read(32'h8, 1'b1);
    axi_write(32'h8, 32'h1, 4'hF, 2, 1'b0, 1'b1);
    axi_read(32'h8, 1'b1);
    pulse_expired();
    axi_write(32'h8, 32'h1, 4'hF, 2, 1'b1, 1'b1);
    axi_read(32'h8, 1'b1);
    // expiry clears running
    axi_write(32'h4, 32'h1, 4'hF, 0, 1'b0, 1'b1);
    pulse_expired();
    axi_read(32'h4, 1'b1);
    // unmapped / read-only targets
    axi_write(32'h10, 32'hDEAD_BEEF, 4'hF, 2, 1'b0, 1'b1);
    axi_write(32'hC, 32'h1234_5678, 4'hF, 0, 1'b0, 1'b1);
    axi_read(32'h40, 1'b1);
    axi_read(32'hC, 1'b1);
    axi_read(32'h0, 1'b1);
    // single byte lane
    axi_write(32'h0, 32'h0000_AA00, 4'b0010, 1, 1'b0, 1'b1);
    axi_read(32'h0, 1'b1);

    // randomized traffic
    for (int k = 0; k < 80; k++) begin
      op = $urandom_range(0, 9);
      ra = pick_addr();
      rd = $urandom;
      if (op < 5) axi_write(ra, rd, 4'($urandom_range(0, 15)), $urandom_range(0, 2), 1'b0, 1'b1);
      else if (op < 9) axi_read(ra, 1'b1);
      else pulse_expired();
    end

    // back-pressure hold, then reset while both responses pend
    b_hold = 1'b1;
    r_hold = 1'b1;
    axi_write(32'h0, 32'h1234_5678, 4'hF, 2, 1'b0, 1'b0);
    axi_read(32'h0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bvalid_hold", 32'(bus.bvalid), 32'h1);
      check("bresp_hold",  32'(bus.bresp),  32'(RESP_OKAY));
      check("rvalid_hold", 32'(bus.rvalid), 32'h1);
      check("rdata_hold",  bus.rdata,       32'h1234_5678);
    end
    reset = 1'b1;
    @(negedge clk);
    exp_b_q.delete();
    exp_r_q.delete();
    model_reset();
    check_idle_outputs("midreset");
    reset  = 1'b0;
    b_hold = 1'b0;
    r_hold = 1'b0;
    axi_read(32'h0, 1'b1);
    axi_write(32'h0, 32'hCAFE_0001, 4'hF, 0, 1'b0, 1'b1);
    axi_read(32'h0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
